// File: rtl/ntm_values_vector_add_scheduler.sv
// Round-robin scheduler sharing one 8-bit values-vector adder between NUM_REQ
// requesters; the 9-bit sum is held in a single-entry response register tagged with the winner id.
module ntm_values_vector_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_ip1,
    input  logic [8*NUM_REQ-1:0] req_ip2,
    output logic [7:0]           adder_ip1,
    output logic [7:0]           adder_ip2,
    input  logic [8:0]           adder_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [8:0]           rsp_data,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [8:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [7:0]       ip1_arr [NUM_REQ];
    logic [7:0]       ip2_arr [NUM_REQ];
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic             can_issue;
    logic             issue;
    logic             consume;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign ip1_arr[gi] = req_ip1[8*gi +: 8];
            assign ip2_arr[gi] = req_ip2[8*gi +: 8];
        end
    endgenerate

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [ID_W:0] cand;
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign can_issue = !rsp_valid_q || rsp_ready;
    assign issue     = !rst && can_issue && grant_found;
    assign consume   = rsp_valid_q && rsp_ready;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = issue && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign adder_ip1 = issue ? ip1_arr[grant_idx] : 8'd0;
    assign adder_ip2 = issue ? ip2_arr[grant_idx] : 8'd0;

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        op_count_d  = op_count_q;
        if (consume) begin
            op_count_d  = op_count_q + CNT_W'(1);
            rsp_valid_d = 1'b0;
        end
        // An accept in the same cycle as a consume overwrites the drained entry.
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = adder_out;
            ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            op_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_ntm_values_vector_add_scheduler.sv
// Bench for the round-robin adder scheduler: directed test-plan scenarios plus random
// traffic, all checked cycle by cycle against a behavioural model of the scheduling rules.
module tb_ntm_values_vector_add_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_ip1;
    logic [8*N-1:0] req_ip2;
    logic [7:0]     adder_ip1;
    logic [7:0]     adder_ip2;
    logic [8:0]     adder_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [8:0]     rsp_data;
    logic [15:0]    op_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_ptr, m_valid, m_id, m_data, m_cnt;

    always #5 clk = ~clk;

    // The shared adder lives outside the scheduler.
    assign adder_out = {1'b0, adder_ip1} + {1'b0, adder_ip2};

    ntm_values_vector_add_scheduler #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ip1   (req_ip1),
        .req_ip2   (req_ip2),
        .adder_ip1 (adder_ip1),
        .adder_ip2 (adder_ip2),
        .adder_out (adder_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .op_count  (op_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_id = 0; m_data = 0; m_cnt = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cycle(input logic r, input logic [N-1:0] v,
                         input logic [8*N-1:0] a, input logic [8*N-1:0] b, input logic rr);
        int g;
        int e_ip1, e_ip2;
        logic [N-1:0] e_ready;
        bit can, iss, cons;
        @(negedge clk);
        rst = r; req_valid = v; req_ip1 = a; req_ip2 = b; rsp_ready = rr;
        #1;
        can = (m_valid == 0) || rr;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        iss = !r && can && (g >= 0);
        e_ready = '0; e_ip1 = 0; e_ip2 = 0;
        if (iss) begin
            e_ready[g] = 1'b1;
            e_ip1 = (a >> (8*g)) & 8'hFF;
            e_ip2 = (b >> (8*g)) & 8'hFF;
        end
        check_val("req_ready", 32'(req_ready), 32'(e_ready));
        check_val("adder_ip1", 32'(adder_ip1), e_ip1);
        check_val("adder_ip2", 32'(adder_ip2), e_ip2);
        check_val("rsp_valid", 32'(rsp_valid), m_valid);
        check_val("rsp_id",    32'(rsp_id),    m_id);
        check_val("rsp_data",  32'(rsp_data),  m_data);
        check_val("op_count",  32'(op_count),  m_cnt);
        $display("cyc rst=%0b v=%b rr=%0b grant=%0d rsp_v=%0b id=%0d data=0x%03h cnt=%0d",
                 r, v, rr, g, rsp_valid, rsp_id, rsp_data, op_count);
        if (r) begin
            model_reset();
        end else begin
            cons = (m_valid != 0) && rr;
            if (cons) begin
                m_cnt = (m_cnt + 1) % 65536;
                m_valid = 0;
            end
            if (iss) begin
                m_data  = e_ip1 + e_ip2;
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % N;
            end
        end
        @(posedge clk);
    endtask

    function automatic logic [8*N-1:0] put8(input logic [8*N-1:0] vec, input int idx, input logic [7:0] val);
        logic [8*N-1:0] r;
        r = vec;
        r[8*idx +: 8] = val;
        return r;
    endfunction

    logic [8*N-1:0] opa, opb;

    initial begin
        rst = 1'b1; req_valid = '0; req_ip1 = '0; req_ip2 = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset values observed, then the single request from requester 2
        cycle(1'b1, 4'b0000, '0, '0, 1'b0);
        opa = put8('0, 2, 8'h12); opb = put8('0, 2, 8'h34);
        cycle(1'b0, 4'b0100, opa, opb, 1'b1);
        #1;
        check_val("tp_rsp_data_046", 32'(rsp_data), 32'h046);
        check_val("tp_rsp_id_2",     32'(rsp_id),   32'd2);
        cycle(1'b0, 4'b0000, '0, '0, 1'b1);
        #1;
        check_val("tp_op_count_1", 32'(op_count), 32'd1);
        // With ptr at 3, all-valid must grant requester 3 first.
        opa = $urandom; opb = $urandom;
        cycle(1'b0, 4'b1111, opa, opb, 1'b1);
        #1;
        check_val("tp_ptr3_grant", 32'(rsp_id), 32'd3);

        // Carry cases on requester 0
        cycle(1'b0, 4'b0001, put8('0, 0, 8'hFF), put8('0, 0, 8'hFF), 1'b1);
        #1;
        check_val("tp_carry_1fe", 32'(rsp_data), 32'h1FE);
        cycle(1'b0, 4'b0001, put8('0, 0, 8'h80), put8('0, 0, 8'h80), 1'b1);
        #1;
        check_val("tp_carry_100", 32'(rsp_data), 32'h100);

        // Round-robin wrap from a fresh reset
        cycle(1'b1, 4'b0000, '0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            opa = $urandom; opb = $urandom;
            cycle(1'b0, 4'b1111, opa, opb, 1'b1);
            #1;
            check_val("tp_rr_id", 32'(rsp_id), k % N);
        end
        cycle(1'b0, 4'b0000, '0, '0, 1'b1);
        #1;
        check_val("tp_rr_count_8", 32'(op_count), 32'd8);

        // Backpressure for three cycles after the first accept
        cycle(1'b1, 4'b0000, '0, '0, 1'b1);
        opa = $urandom; opb = $urandom;
        cycle(1'b0, 4'b1111, opa, opb, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 4'b1111, opa, opb, 1'b0);
        cycle(1'b0, 4'b1111, opa, opb, 1'b1);
        #1;
        check_val("tp_bp_regrant", 32'(rsp_id), 32'd1);

        // Reset while a result is held and stalled
        cycle(1'b0, 4'b1111, opa, opb, 1'b0);
        cycle(1'b1, 4'b1111, opa, opb, 1'b0);
        #1;
        check_val("tp_rst_valid", 32'(rsp_valid), 32'd0);
        check_val("tp_rst_data",  32'(rsp_data),  32'd0);
        check_val("tp_rst_count", 32'(op_count),  32'd0);
        cycle(1'b0, 4'b0110, opa, opb, 1'b1);
        #1;
        check_val("tp_rst_lowest", 32'(rsp_id), 32'd1);

        // Random traffic with sporadic stalls and resets
        for (int k = 0; k < 400; k++) begin
            opa = {$urandom, $urandom};
            opb = {$urandom, $urandom};
            cycle(($urandom_range(0, 59) == 0), N'($urandom),
                  opa, opb, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
